// File: rtl/serial_cmd_decoder_pkg.sv
// Shared constants and state encoding for the serial command frame decoder.
package serial_cmd_decoder_pkg;

    localparam logic [7:0] SOF_BYTE   = 8'hFF;
    localparam logic [7:0] SPACE_BYTE = 8'h00;
    localparam logic [7:0] EOF_BYTE   = 8'hEE;

    // Bytes around the payload: two SOF, one space, one LEN, two EOF.
    localparam int FRAME_OVERHEAD = 6;

    // Index of the first payload byte (after SOF, SOF, space, LEN).
    localparam int HEADER_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        WAIT,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/fifo.sv
// Simple synchronous FIFO with a registered read port: out_data updates on
// the edge that samples pop, so data is valid the cycle after the strobe.
// FIFO_SIZE is expected to be a power of two so the pointers wrap naturally.
module fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_SIZE  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int AW = $clog2(FIFO_SIZE);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_SIZE);

    logic [DATA_WIDTH-1:0] mem [FIFO_SIZE];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && (count != FULL_COUNT);
    assign do_pop  = pop && (count != '0);

    // Storage array; writes ignored when full.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers, occupancy and registered read data; pops on empty hold out_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_data <= '0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                out_data <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_cmd_decoder.sv
// Pops one framed command (FF FF 00 LEN payload EE EE) from the receive FIFO,
// validates framing byte by byte, unpacks the payload into r0..r7 and holds a
// sticky done/success result until the consumer acknowledges it.
module serial_cmd_decoder #(
    parameter int MAX_CMD_PAYLOAD_BYTES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_ready,
    input  logic [7:0] data,
    input  logic       cmd_processed_received,
    output logic       cmd_read_clk,
    output logic       cmd_processed,
    output logic [7:0] cmd_bytes_processed,
    output logic       cmd_decode_success,
    output logic [7:0] cmd_payload_r0,
    output logic [7:0] cmd_payload_r1,
    output logic [7:0] cmd_payload_r2,
    output logic [7:0] cmd_payload_r3,
    output logic [7:0] cmd_payload_r4,
    output logic [7:0] cmd_payload_r5,
    output logic [7:0] cmd_payload_r6,
    output logic [7:0] cmd_payload_r7
);

    import serial_cmd_decoder_pkg::*;

    localparam logic [7:0] MAX_LEN     = 8'(MAX_CMD_PAYLOAD_BYTES);
    localparam logic [7:0] LEN_INDEX   = 8'(HEADER_BYTES - 1);
    localparam logic [7:0] PAYLOAD_IDX = 8'(HEADER_BYTES);
    localparam logic [7:0] LAST_OFFSET = 8'(FRAME_OVERHEAD - 1);

    state_t     state;
    state_t     next_state;
    logic       ready_prev;
    logic       start;
    logic [7:0] len;
    logic [7:0] byte_count;
    logic       success;
    logic [7:0] payload [8];
    logic       byte_ok;
    logic       payload_byte;
    logic       last_byte;
    logic [2:0] slot;

    assign start = (state == IDLE) && cmd_ready && !ready_prev;

    // Payload byte k arrives at index k+4; adding 4 modulo 8 is the same as subtracting 4.
    assign slot = byte_count[2:0] + 3'd4;

    // The final EOF sits at index LEN+5; LEN is still 0 before index 3 so the guard keeps it honest.
    assign last_byte = (byte_count > LEN_INDEX) && (byte_count == len + LAST_OFFSET);

    // Check the byte in data against the field its index falls in.
    always_comb begin
        byte_ok      = 1'b0;
        payload_byte = 1'b0;
        if (byte_count < 8'd2) begin
            byte_ok = (data == SOF_BYTE);
        end else if (byte_count == 8'd2) begin
            byte_ok = (data == SPACE_BYTE);
        end else if (byte_count == LEN_INDEX) begin
            byte_ok = (data <= MAX_LEN);
        end else if (byte_count < len + PAYLOAD_IDX) begin
            byte_ok      = 1'b1;
            payload_byte = 1'b1;
        end else begin
            byte_ok = (data == EOF_BYTE);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: three cycles per byte, stop early on the first bad byte.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = POP;
            POP:     next_state = WAIT;
            WAIT:    next_state = CHECK;
            CHECK:   next_state = (!byte_ok || last_byte) ? DONE : POP;
            DONE:    if (cmd_processed_received) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded directly from state.
    always_comb begin
        cmd_read_clk  = (state == POP);
        cmd_processed = (state == DONE);
    end

    // Datapath: edge detector, byte counter, LEN, payload registers and sticky success.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_prev <= 1'b0;
            byte_count <= '0;
            len        <= '0;
            success    <= 1'b0;
            payload    <= '{default: '0};
        end else begin
            ready_prev <= cmd_ready;
            if (start) begin
                byte_count <= '0;
                len        <= '0;
                success    <= 1'b0;
                payload    <= '{default: '0};
            end else if (state == CHECK) begin
                byte_count <= byte_count + 1'b1;
                if (byte_count == LEN_INDEX && byte_ok) begin
                    len <= data;
                end
                if (payload_byte) begin
                    payload[slot] <= data;
                end
                if (byte_ok && last_byte) begin
                    success <= 1'b1;
                end
            end else if (state == DONE && cmd_processed_received) begin
                success <= 1'b0;
            end
        end
    end

    assign cmd_bytes_processed = byte_count;
    assign cmd_decode_success  = success;
    assign cmd_payload_r0      = payload[0];
    assign cmd_payload_r1      = payload[1];
    assign cmd_payload_r2      = payload[2];
    assign cmd_payload_r3      = payload[3];
    assign cmd_payload_r4      = payload[4];
    assign cmd_payload_r5      = payload[5];
    assign cmd_payload_r6      = payload[6];
    assign cmd_payload_r7      = payload[7];

endmodule

// File: tb/tb_serial_cmd_decoder.sv
// Self-checking bench for serial_cmd_decoder fed from the receive FIFO.
// Frames are stored MSB-first in a 128-bit word (byte 0 in bits 127:120);
// expected payload registers are packed r0 (MSB) .. r7 (LSB).
module tb_serial_cmd_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_ready;
    logic [7:0] data;
    logic       cmd_processed_received;
    logic       cmd_read_clk;
    logic       cmd_processed;
    logic [7:0] cmd_bytes_processed;
    logic       cmd_decode_success;
    logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic       fifo_clear;
    logic       fifo_push;
    logic [7:0] fifo_in;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [127:0] frame;
        int           n;
        logic         succ;
        logic [7:0]   cnt;
        logic [63:0]  regs;
    } vec_t;

    vec_t vecs [8];

    localparam logic [127:0] VALID6 = 128'hFFFF0006_11223344_5566EEEE_00000000;
    localparam logic [63:0]  REGS6  = 64'h11223344_55660000;

    always #5 clk = ~clk;

    serial_cmd_decoder #(.MAX_CMD_PAYLOAD_BYTES(8)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .cmd_ready              (cmd_ready),
        .data                   (data),
        .cmd_processed_received (cmd_processed_received),
        .cmd_read_clk           (cmd_read_clk),
        .cmd_processed          (cmd_processed),
        .cmd_bytes_processed    (cmd_bytes_processed),
        .cmd_decode_success     (cmd_decode_success),
        .cmd_payload_r0         (r0),
        .cmd_payload_r1         (r1),
        .cmd_payload_r2         (r2),
        .cmd_payload_r3         (r3),
        .cmd_payload_r4         (r4),
        .cmd_payload_r5         (r5),
        .cmd_payload_r6         (r6),
        .cmd_payload_r7         (r7)
    );

    fifo #(.DATA_WIDTH(8), .FIFO_SIZE(16)) rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (fifo_clear),
        .push     (fifo_push),
        .in_data  (fifo_in),
        .pop      (cmd_read_clk),
        .out_data (data)
    );

    // Compare one observed value against its expected value and tally it.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Flush the FIFO, then push the first n bytes of a frame.
    task automatic pushFrame(input logic [127:0] f, input int n);
        @(negedge clk);
        fifo_clear = 1'b1;
        @(negedge clk);
        fifo_clear = 1'b0;
        for (int k = 0; k < n; k++) begin
            fifo_in   = f[127 - 8 * k -: 8];
            fifo_push = 1'b1;
            @(negedge clk);
        end
        fifo_push = 1'b0;
    endtask

    // Wait (bounded) for cmd_processed; cycles counts edges from the start edge.
    task automatic waitDone(output int cycles);
        cycles = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cmd_processed) break;
        end
    endtask

    // Give cmd_ready a fresh 0->1 edge and wait for the decode to finish.
    task automatic applyStimulus(output int cycles);
        @(negedge clk);
        cmd_ready = 1'b0;
        @(negedge clk);
        cmd_ready = 1'b1;
        waitDone(cycles);
    endtask

    // Acknowledge; done and success must both drop on the next edge.
    task automatic acknowledge(input string tag, input logic keep_ready);
        @(negedge clk);
        cmd_processed_received = 1'b1;
        cmd_ready = keep_ready;
        @(posedge clk);
        #1;
        checkOutput({tag, "_processed_cleared"}, 64'(cmd_processed), 64'd0);
        checkOutput({tag, "_success_cleared"}, 64'(cmd_decode_success), 64'd0);
        @(negedge clk);
        cmd_processed_received = 1'b0;
    endtask

    function automatic logic [63:0] regsNow();
        return {r0, r1, r2, r3, r4, r5, r6, r7};
    endfunction

    initial begin
        int    cycles;
        int    pops;
        string nm;

        vecs[0] = '{VALID6, 12, 1'b1, 8'd12, REGS6};
        vecs[1] = '{128'hFFFF0008_A0A1A2A3_A4A5A6A7_EEEE0000, 14, 1'b1, 8'd14, 64'hA0A1A2A3_A4A5A6A7};
        vecs[2] = '{128'hFF000611_00000000_00000000_00000000, 4, 1'b0, 8'd2, 64'h0};
        vecs[3] = '{128'hFFFF0100_00000000_00000000_00000000, 4, 1'b0, 8'd3, 64'h0};
        vecs[4] = '{128'hFFFF0009_11000000_00000000_00000000, 5, 1'b0, 8'd4, 64'h0};
        vecs[5] = '{128'hFFFF0002_1122EE00_00000000_00000000, 8, 1'b0, 8'd8, 64'h11220000_00000000};
        vecs[6] = '{128'hFFFF0000_EEEE0000_00000000_00000000, 6, 1'b1, 8'd6, 64'h0};
        vecs[7] = '{128'hFFFF0001_5A00EE00_00000000_00000000, 7, 1'b0, 8'd6, 64'h5A000000_00000000};

        rst = 1'b0;
        cmd_ready = 1'b0;
        cmd_processed_received = 1'b0;
        fifo_clear = 1'b0;
        fifo_push = 1'b0;
        fifo_in = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("reset_read_clk", 64'(cmd_read_clk), 64'd0);
        checkOutput("reset_processed", 64'(cmd_processed), 64'd0);
        checkOutput("reset_success", 64'(cmd_decode_success), 64'd0);
        checkOutput("reset_bytes", 64'(cmd_bytes_processed), 64'd0);
        checkOutput("reset_regs", regsNow(), 64'd0);
        rst = 1'b1;

        // Table of whole-frame vectors.
        for (int i = 0; i < 8; i++) begin
            nm = $sformatf("vec%0d", i);
            pushFrame(vecs[i].frame, vecs[i].n);
            applyStimulus(cycles);
            checkOutput({nm, "_latency"}, 64'(cycles), 64'(3 * int'(vecs[i].cnt) + 1));
            checkOutput({nm, "_success"}, 64'(cmd_decode_success), 64'(vecs[i].succ));
            checkOutput({nm, "_bytes"}, 64'(cmd_bytes_processed), 64'(vecs[i].cnt));
            checkOutput({nm, "_regs"}, regsNow(), vecs[i].regs);
            acknowledge(nm, 1'b0);
            checkOutput({nm, "_regs_held"}, regsNow(), vecs[i].regs);
        end

        // Mid-decode acknowledge and cmd_ready re-edge must both be ignored.
        pushFrame(VALID6, 12);
        @(negedge clk);
        cmd_ready = 1'b1;
        repeat (5) @(negedge clk);
        cmd_processed_received = 1'b1;
        cmd_ready = 1'b0;
        @(negedge clk);
        cmd_processed_received = 1'b0;
        cmd_ready = 1'b1;
        waitDone(cycles);
        checkOutput("ignore_ack_processed", 64'(cmd_processed), 64'd1);
        checkOutput("ignore_ack_success", 64'(cmd_decode_success), 64'd1);
        checkOutput("ignore_ack_bytes", 64'(cmd_bytes_processed), 64'd12);
        checkOutput("ignore_ack_regs", regsNow(), REGS6);

        // cmd_ready held high through the acknowledge: no restart.
        acknowledge("hold_high", 1'b1);
        pushFrame(128'hFFFF0001_77EEEE00_00000000_00000000, 7);
        pops = 0;
        repeat (20) begin
            @(negedge clk);
            if (cmd_read_clk) pops++;
        end
        checkOutput("hold_high_no_pops", 64'(pops), 64'd0);
        checkOutput("hold_high_idle", 64'(cmd_processed), 64'd0);
        applyStimulus(cycles);
        checkOutput("hold_high_then_edge_success", 64'(cmd_decode_success), 64'd1);
        checkOutput("hold_high_then_edge_bytes", 64'(cmd_bytes_processed), 64'd7);
        checkOutput("hold_high_then_edge_regs", regsNow(), 64'h77000000_00000000);
        acknowledge("hold_high_then_edge", 1'b0);

        // Reset asserted mid-decode aborts at once; the next edge decodes normally.
        pushFrame(VALID6, 12);
        @(negedge clk);
        cmd_ready = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midreset_read_clk", 64'(cmd_read_clk), 64'd0);
        checkOutput("midreset_processed", 64'(cmd_processed), 64'd0);
        checkOutput("midreset_success", 64'(cmd_decode_success), 64'd0);
        checkOutput("midreset_bytes", 64'(cmd_bytes_processed), 64'd0);
        checkOutput("midreset_regs", regsNow(), 64'd0);
        @(negedge clk);
        cmd_ready = 1'b0;
        rst = 1'b1;
        pushFrame(VALID6, 12);
        applyStimulus(cycles);
        checkOutput("after_reset_latency", 64'(cycles), 64'd37);
        checkOutput("after_reset_success", 64'(cmd_decode_success), 64'd1);
        checkOutput("after_reset_bytes", 64'(cmd_bytes_processed), 64'd12);
        checkOutput("after_reset_regs", regsNow(), REGS6);
        acknowledge("after_reset", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_cmd_decoder.md
# serial_cmd_decoder

Frame decoder between the UART receive FIFO and the command processor. On a `cmd_ready` rising edge it pops one framed command byte-by-byte from the FIFO and validates the framing. It then unpacks up to `MAX_CMD_PAYLOAD_BYTES` payload bytes into registers `r0..r7` and reports success or failure through a sticky done/acknowledge handshake.

## Interface
- `MAX_CMD_PAYLOAD_BYTES`, 8: maximum accepted payload length; legal range 1..8.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_ready`  in  1  level from the receiver; its rising edge starts a decode.
- `data`  in  8  FIFO `out_data`; valid one cycle after a pop strobe.
- `cmd_processed_received`  in  1  acknowledge from the consumer; clears the done flags.
- `cmd_read_clk`  out  1  one-cycle FIFO pop strobe.
- `cmd_processed`  out  1  sticky done flag.
- `cmd_bytes_processed`  out  8  number of bytes popped in the current or last decode.
- `cmd_decode_success`  out  1  frame valid; meaningful only while `cmd_processed`=1.
- `cmd_payload_r0` … `cmd_payload_r7`  out  8 each  payload bytes 0..7.

## Operation
- Frame format: `FF FF 00 LEN P0..P(LEN-1) EE EE`, for a total of LEN+6 bytes.
- States and transitions:
  - IDLE → POP on a `cmd_ready` 0→1 edge, using a registered previous value.
  - POP: asserts `cmd_read_clk`; → WAIT.
  - WAIT → CHECK.
  - CHECK: samples `data`, increments `cmd_bytes_processed`, checks the byte against its field; → POP if more bytes remain, otherwise → DONE.
  - DONE → IDLE on `cmd_processed_received`=1.
- On start: clear `cmd_bytes_processed`, `cmd_decode_success` and r0..r7 to 0.
- Byte 0 and byte 1 must equal 0xFF.
- Byte 2 must equal 0x00.
- Byte 3 is LEN:
  - LEN > `MAX_CMD_PAYLOAD_BYTES` is a failure.
  - LEN = 0 is legal; decoding proceeds directly to EOF.
- Payload byte k is stored in r_k.
- The last two bytes must each equal 0xEE.
- Any mismatch stops the decode immediately: no further pops, → DONE with `cmd_decode_success`=0, and `cmd_bytes_processed` equal to the bytes consumed including the bad one. The remaining FIFO content is left for the system to flush.
- Success: all LEN+6 bytes match → DONE with `cmd_decode_success`=1.
- An empty FIFO is not detected; stale data normally fails the framing checks.
- r0..r7 hold their values until the next decode starts.

## Timing
- Reset values: every output is 0; state is IDLE.
- Each byte takes 3 cycles (POP, WAIT, CHECK).
- `cmd_processed` rises in the cycle after the final CHECK.
- Latency for a LEN=6 frame: 36 cycles + 1 from the start edge.
- `cmd_processed` and `cmd_decode_success` stay high until acknowledged. On `cmd_processed_received`=1 in DONE, both clear on the next edge.
- Acknowledges outside DONE are ignored.
- `cmd_ready` edges outside IDLE are ignored.
- If `cmd_ready` is still high after acknowledge, no restart occurs; a fresh 0→1 edge is required.
- Reset asserted mid-decode aborts immediately to the reset values.

## Structure
- Shared package holds:
  - constants `SOF_BYTE`=8'hFF, `SPACE_BYTE`=8'h00, `EOF_BYTE`=8'hEE;
  - the state encoding (IDLE, POP, WAIT, CHECK, DONE);
  - the frame overhead value 6.
- No sub-module inside the decoder.
- The FIFO is a separate existing library module, `fifo`, with parameters `DATA_WIDTH`=8 and `FIFO_SIZE`=16:
  - `clear` is an active-high flush;
  - `push` writes `in_data`;
  - `pop` advances `out_data` with a one-cycle delay.
- The bench connects `cmd_read_clk` to `pop` and `out_data` to `data`.

## Test plan
- Valid frame: push `FF FF 00 06 11 22 33 44 55 66 EE EE`, pulse `cmd_ready` → `cmd_processed`=1, success=1, r0..r5=11,22,33,44,55,66, r6=r7=00, `cmd_bytes_processed`=12.
- Acknowledge, then a second valid frame with LEN=8 (`A0..A7`) → success=1, r0..r7=A0..A7, bytes=14; `cmd_processed` dropped to 0 the cycle after the first acknowledge.
- Missing SOF: push `FF 00 06 …` → success=0, bytes=2, then flush the FIFO.
- Missing space byte: push `FF FF 01 …` → success=0, bytes=3. LEN=9: push `FF FF 00 09 …` → success=0, bytes=4.
- Missing EOF: `FF FF 00 02 11 22 EE 00` → success=0, bytes=8, r0=11, r1=22.
- Assert `rst` low mid-decode → all outputs 0 immediately; the next `cmd_ready` edge decodes normally.
